multi_project_io_mux: RTL and testbench

- Parametrised successor to the single-macro user-area hookup.
- Hosts NUM_PROJ user projects behind one IO_W-bit pad slice and exposes a Wishbone-programmable project select.
- Performs a glitch-safe switch-over: isolate pads → hold target in reset → release.
- Sits between the user-area pads and the per-project macros; unselected projects are kept in reset with their inputs tied low.

---
 rtl/multi_project_io_mux.sv | 154 +++++++++++++++
 tb/tb_multi_project_io_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_project_io_mux.sv
// Hosts NUM_PROJ user projects behind one pad slice with a Wishbone-programmed select.
// Switching isolates the pads, holds the target in reset for HOLD cycles, then releases it.
module multi_project_io_mux #(
  parameter int          NUM_PROJ     = 4,
  parameter int          SEL_W        = $clog2(NUM_PROJ),
  parameter int          IO_W         = 16,
  parameter int          HOLD_DEFAULT = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [IO_W-1:0]          io_in,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  output logic [NUM_PROJ*IO_W-1:0] proj_io_in,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb,
  output logic [NUM_PROJ-1:0]      proj_rst_n,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ISOLATE = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] req_sel, active_sel;
  logic [7:0]       hold_cycles, cnt;
  logic             sel_err, pend_switch, ack;
  logic [31:0]      rdata, rd_mux;

  logic             req, wr, ctrl_wr, status_wr, hold_wr;
  logic             sel_ok, soft_rst, switch_req;
  logic [SEL_W-1:0] sel_new;
  logic             unused_bits;

  assign req       = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]) && !ack;
  assign wr        = req && wbs_we_i && wbs_sel_i[0];
  assign ctrl_wr   = wr && (wbs_adr_i[3:2] == 2'd0);
  assign status_wr = wr && (wbs_adr_i[3:2] == 2'd1);
  assign hold_wr   = wr && (wbs_adr_i[3:2] == 2'd2);

  // The full 7-bit field is range-checked so out-of-range values are not silently truncated.
  assign sel_ok     = ({25'd0, wbs_dat_i[6:0]} < 32'(NUM_PROJ));
  assign sel_new    = wbs_dat_i[SEL_W-1:0];
  assign soft_rst   = wbs_dat_i[7];
  assign switch_req = ctrl_wr && ((sel_ok && (sel_new != active_sel)) || soft_rst);

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:9]};

  assign busy      = (state != S_RUN);
  assign wbs_ack_o = ack;
  assign wbs_dat_o = rdata;

  always_comb begin
    rd_mux = '0;
    case (wbs_adr_i[3:2])
      2'd0: rd_mux[SEL_W-1:0] = req_sel;
      2'd1: begin
        rd_mux[SEL_W-1:0] = active_sel;
        rd_mux[5:4]       = state;
        rd_mux[6]         = busy;
        rd_mux[8]         = sel_err;
      end
      2'd2:    rd_mux[7:0] = hold_cycles;
      default: rd_mux = '0;
    endcase
  end

  // Reset parks the FSM in ISOLATE so project 0 gets the same full hold sequence as a switch.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= S_ISOLATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      req_sel     <= '0;
      active_sel  <= '0;
      hold_cycles <= 8'(HOLD_DEFAULT);
      cnt         <= 8'(HOLD_DEFAULT);
      sel_err     <= 1'b0;
      pend_switch <= 1'b0;
      ack         <= 1'b0;
      rdata       <= '0;
    end else begin
      ack   <= req;
      rdata <= (req && !wbs_we_i) ? rd_mux : '0;

      if (state == S_ISOLATE) begin
        active_sel <= req_sel;
        cnt        <= hold_cycles;
      end else if (state == S_HOLD) begin
        cnt <= cnt - 8'd1;
      end

      // A write landing on the ISOLATE entry edge must survive, so set overrides clear.
      if (state_nxt == S_ISOLATE) pend_switch <= 1'b0;
      if (switch_req)             pend_switch <= 1'b1;

      if (ctrl_wr && sel_ok)  req_sel <= sel_new;
      if (ctrl_wr && !sel_ok) sel_err <= 1'b1;
      if (status_wr && wbs_dat_i[8]) sel_err <= 1'b0;
      if (hold_wr) hold_cycles <= (wbs_dat_i[7:0] == 8'd0) ? 8'd1 : wbs_dat_i[7:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    io_out     = '0;
    io_oeb     = '1;
    proj_io_in = '0;
    proj_rst_n = '0;
    case (state)
      S_RUN: begin
        if (pend_switch) state_nxt = S_ISOLATE;
        for (int k = 0; k < NUM_PROJ; k++) begin
          if (active_sel == SEL_W'(k)) begin
            io_out                     = proj_io_out[k*IO_W +: IO_W];
            io_oeb                     = proj_io_oeb[k*IO_W +: IO_W];
            proj_io_in[k*IO_W +: IO_W] = io_in;
            proj_rst_n[k]              = 1'b1;
          end
        end
      end
      S_ISOLATE: state_nxt = S_HOLD;
      S_HOLD: begin
        if (cnt <= 8'd1) state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        state_nxt = pend_switch ? S_ISOLATE : S_RUN;
        for (int k = 0; k < NUM_PROJ; k++) begin
          if (active_sel == SEL_W'(k)) proj_rst_n[k] = 1'b1;
        end
      end
      default: state_nxt = S_ISOLATE;
    endcase
  end

endmodule

// File: tb/tb_multi_project_io_mux.sv
// Directed bench for multi_project_io_mux: reset sequence, switching, errors, soft reset, async reset.
module tb_multi_project_io_mux;
  localparam int          NUM_PROJ = 4;
  localparam int          IO_W     = 16;
  localparam logic [31:0] BASE     = 32'h3000_0000;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]               sel = 4'h0;
  logic [31:0]              adr = 32'h0, wdat = 32'h0;
  logic                     ack;
  logic [31:0]              rdat;
  logic [IO_W-1:0]          io_in = 16'hBEEF;
  logic [IO_W-1:0]          io_out, io_oeb;
  logic [NUM_PROJ*IO_W-1:0] proj_io_in, proj_io_out, proj_io_oeb;
  logic [NUM_PROJ-1:0]      proj_rst_n;
  logic                     busy;

  int n_checks = 0;
  int n_errors = 0;

  multi_project_io_mux #(.NUM_PROJ(NUM_PROJ), .IO_W(IO_W), .HOLD_DEFAULT(8), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_in(proj_io_in), .proj_io_out(proj_io_out), .proj_io_oeb(proj_io_oeb),
    .proj_rst_n(proj_rst_n), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = 32'h0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = wr; sel = 4'hF; adr = addr; wdat = data;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        rd  = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    if (!got) check("wb_ack_timeout", 64'(got), 64'(1'b1));
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, BASE | {28'd0, off, 2'b00}, data, dummy);
  endtask

  task automatic wb_read(input logic [1:0] off, output logic [31:0] rd);
    wb_xfer(1'b0, BASE | {28'd0, off, 2'b00}, 32'h0, rd);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Counts consecutive cycles (starting with the current one) where every project is in reset.
  task automatic count_low(output int n);
    n = 0;
    while (proj_rst_n == '0 && n < 60) begin
      n++;
      step();
    end
  endtask

  task automatic wait_run(input string tag);
    int i;
    i = 0;
    while (busy && i < 60) begin
      i++;
      step();
    end
    if (busy) check(tag, 64'(busy), 64'(1'b0));
  endtask

  initial begin
    int          n;
    int          acks;
    logic [31:0] rd;

    for (int k = 0; k < NUM_PROJ; k++) begin
      proj_io_out[k*IO_W +: IO_W] = 16'(16'h1111 * (k + 1));
      proj_io_oeb[k*IO_W +: IO_W] = 16'(16'h0F00 + k);
    end

    // Reset values and release sequence
    repeat (3) @(posedge clk);
    #1;
    check("rst_io_out",     64'(io_out),     64'h0);
    check("rst_io_oeb",     64'(io_oeb),     64'hFFFF);
    check("rst_proj_io_in", 64'(proj_io_in), 64'h0);
    check("rst_proj_rst_n", 64'(proj_rst_n), 64'h0);
    check("rst_ack",        64'(ack),        64'h0);
    check("rst_dat",        64'(rdat),       64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_low(n);
    check("rel_low_cycles", 64'(n),          64'd9);
    check("rel_rst_n",      64'(proj_rst_n), 64'b0001);
    check("rel_oeb_iso",    64'(io_oeb),     64'hFFFF);
    check("rel_busy",       64'(busy),       64'h1);
    step();
    check("run0_busy",      64'(busy),       64'h0);
    check("run0_io_out",    64'(io_out),     64'h1111);
    check("run0_io_oeb",    64'(io_oeb),     64'h0F00);
    check("run0_proj_in",   64'(proj_io_in), 64'h0000_0000_0000_BEEF);

    // Switch to project 2
    wb_write(2'd0, 32'd2);
    check("sw2_ackcyc_out", 64'(io_out),     64'h1111);
    step();
    check("sw2_iso_oeb",    64'(io_oeb),     64'hFFFF);
    check("sw2_iso_out",    64'(io_out),     64'h0);
    count_low(n);
    check("sw2_low_cycles", 64'(n),          64'd9);
    check("sw2_rst_n",      64'(proj_rst_n), 64'b0100);
    step();
    check("sw2_io_out",     64'(io_out),     64'h3333);
    check("sw2_io_oeb",     64'(io_oeb),     64'h0F02);
    check("sw2_proj_in",    64'(proj_io_in), 64'h0000_BEEF_0000_0000);
    check("sw2_busy",       64'(busy),       64'h0);

    // Out-of-range select sets sel_err without switching
    wb_write(2'd0, 32'd7);
    step();
    check("err_no_switch",  64'(busy),       64'h0);
    wb_read(2'd1, rd);
    check("err_status",     64'(rd),         64'h102);
    wb_read(2'd0, rd);
    check("err_req_sel",    64'(rd),         64'h2);
    wb_write(2'd1, 32'h100);
    wb_read(2'd1, rd);
    check("err_cleared",    64'(rd),         64'h002);

    // Retarget during HOLD: project 3 gets a single RELEASE cycle, then project 1 wins
    wb_write(2'd0, 32'd3);
    repeat (3) step();
    wb_write(2'd0, 32'd1);
    n = 0;
    while (proj_rst_n == '0 && n < 40) begin
      n++;
      step();
    end
    check("rt_rel3",        64'(proj_rst_n), 64'b1000);
    check("rt_rel3_oeb",    64'(io_oeb),     64'hFFFF);
    step();
    check("rt_reiso",       64'(proj_rst_n), 64'b0000);
    check("rt_reiso_oeb",   64'(io_oeb),     64'hFFFF);
    wait_run("rt_timeout");
    check("rt_rst_n",       64'(proj_rst_n), 64'b0010);
    check("rt_io_out",      64'(io_out),     64'h2222);
    wb_read(2'd1, rd);
    check("rt_status",      64'(rd),         64'h001);

    // Same-select write is a no-op
    wb_write(2'd0, 32'd1);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy || io_oeb != 16'h0F01) acks++;
    end
    check("nop_glitches",   64'(acks),       64'd0);

    // HOLD=0 stores 1; soft reset on the same select
    wb_write(2'd2, 32'd0);
    wb_read(2'd2, rd);
    check("hold_min",       64'(rd),         64'd1);
    wb_write(2'd0, 32'h81);
    step();
    count_low(n);
    check("soft_low",       64'(n),          64'd2);
    check("soft_rst_n",     64'(proj_rst_n), 64'b0010);
    wait_run("soft_timeout");
    check("soft_io_out",    64'(io_out),     64'h2222);

    // Reset asserted mid-HOLD
    wb_write(2'd2, 32'd5);
    wb_write(2'd0, 32'd2);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("mid_oeb",        64'(io_oeb),     64'hFFFF);
    check("mid_rst_n",      64'(proj_rst_n), 64'h0);
    check("mid_proj_in",    64'(proj_io_in), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_low(n);
    check("mid_rel_low",    64'(n),          64'd9);
    wait_run("mid_timeout");
    check("mid_rst_n_run",  64'(proj_rst_n), 64'b0001);
    wb_read(2'd1, rd);
    check("mid_status",     64'(rd),         64'h000);
    wb_read(2'd2, rd);
    check("mid_hold",       64'(rd),         64'd8);

    // Asynchronous reset from RUN, no clock edge needed
    step();
    rst_n = 1'b0;
    #1;
    check("async_oeb",      64'(io_oeb),     64'hFFFF);
    check("async_out",      64'(io_out),     64'h0);
    check("async_rst_n",    64'(proj_rst_n), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_run("async_timeout");
    check("async_back",     64'(io_out),     64'h1111);

    // Back-to-back requests: one ack every second cycle, dat_o zero between
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE | 32'h8;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      else if (rdat != 32'h0) acks += 100;
    end
    cyc = 1'b0; stb = 1'b0;
    check("b2b_acks",       64'(acks),       64'd2);

    // Reserved register and out-of-window access
    wb_read(2'd3, rd);
    check("reserved_rd",    64'(rd),         64'h0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h10;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("window_noack",   64'(acks),       64'd0);
    check("idle_dat",       64'(rdat),       64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
